pulse_batcher: RTL
==================

// Module: pulse_batcher
// PURPOSE
//  Sits directly downstream of the synchronise-and-edge-detect stage; consumes its
//  single-cycle event pulses and groups them into batches. A batch closes on a count
//  threshold or on a timeout after its first pulse. The count is then handed on over
//  valid/ready. Pulses arriving while a batch waits for acceptance are buffered, not lost.
// PARAMETERS
//  COUNT_WIDTH    8   width of batch count, threshold and pending counters
//  TIMEOUT_WIDTH  16  width of timeout value and batch timer
// PORTS
//  clk            in   1              single clock, all state on rising edge
//  rst            in   1              asynchronous, active-low reset
//  enable         in   1              gates pulse capture and timer advance
//  pulse_in       in   1              one-cycle event pulse from edge-detect stage
//  threshold      in   COUNT_WIDTH    pulses per batch; 0 treated as 1
//  timeout        in   TIMEOUT_WIDTH  enabled cycles after first pulse; 0 = no timeout
//  out_valid      out  1              batch count available
//  out_ready      in   1              consumer accepts when out_valid & out_ready
//  out_count      out  COUNT_WIDTH    pulses in presented batch, stable while out_valid
//  overflow       out  1              sticky: a pulse was dropped (pending saturated)
//  clear_overflow in   1              synchronous clear of overflow
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; acc, timer, pending, out_count=0; out_valid=0; overflow=0.
//  Pulse counted only in a cycle with pulse_in=1 and enable=1 ("ev"); enable=0 freezes timer.
//  threshold/timeout latched into thr_q/to_q when a batch opens; later changes affect next batch.
//  IDLE: on ev open batch: acc=1, timer=0, latch thr/to -> ACCUM; if thr_q<=1 -> REPORT directly
//        with out_count=1.
//  ACCUM: acc_n = acc + ev; timer += enable.
//   close if acc_n >= thr_q, or (to_q!=0 and timer+enable == to_q).
//   close: out_count<=acc_n, out_valid<=1 next edge -> REPORT. Latency: closing pulse at cycle
//   N -> out_valid=1 at N+1.
//   acc never exceeds thr_q, so no wrap.
//  REPORT: out_valid=1, out_count held. Each ev increments pending (saturating at 2^COUNT_WIDTH-1);
//   ev at saturation is dropped and sets overflow.
//   On handshake (out_valid & out_ready), with p = pending + ev (saturating):
//    p==0 -> IDLE, out_valid=0.
//    p>0  -> open new batch: acc=p, timer=0, latch thr/to, pending=0, out_valid=0.
//            If p >= new thr_q -> REPORT again next cycle with out_count=p
//            (out_valid low for exactly one cycle).
//    otherwise -> ACCUM.
//  out_valid never drops without a handshake; out_count never changes while out_valid=1.
//  overflow: set wins over clear_overflow in the same cycle.
//  Reset mid-operation: in-flight batch and pending pulses discarded, no out_valid after release.
//  Counter widths: acc/pending/out_count COUNT_WIDTH, timer TIMEOUT_WIDTH; saturate, never wrap.
//  No combinational path from inputs to outputs; all outputs registered.
// TESTING
//  1 thr=4, to=0, out_ready=1, pulses cycles 0,2,4,6 -> out_valid=1 cycle 7 only, out_count=4, back to IDLE.
//  2 thr=10, to=5, one pulse cycle 0, enable=1 -> out_valid at cycle 6 (timer hits 5 at edge 5), out_count=1.
//  3 thr=4, out_ready=0 after close, 3 pulses in REPORT, then ready=1 -> ACCUM acc=3; 1 more pulse -> count 4.
//  4 COUNT_WIDTH=4, out_ready=0, 16 pulses in REPORT -> pending=15, overflow=1; clear_overflow pulse -> overflow=0.
//  5 thr=0 -> every pulse yields batch out_count=1; enable=0 pulses -> ignored, timer frozen.
//  6 rst low during ACCUM with acc=2 -> all outputs 0 immediately; after release no out_valid without pulses.

Source files
------------

// File: rtl/pulse_batcher.sv
// Groups single-cycle event pulses into batches closed by a count threshold or a
// timeout, and hands each batch count downstream over a valid/ready interface.
module pulse_batcher #(
  parameter int COUNT_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     pulse_in,
  input  logic [COUNT_WIDTH-1:0]   threshold,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COUNT_WIDTH-1:0]   out_count,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  // RELOAD is the single cycle with out_valid low between two back-to-back reports.
  typedef enum logic [1:0] {IDLE, ACCUM, RELOAD, REPORT} state_t;

  localparam logic [COUNT_WIDTH-1:0]   CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]   CNT_MAX = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] TMR_MAX = '1;

  state_t                   state;
  logic [COUNT_WIDTH-1:0]   acc;
  logic [COUNT_WIDTH-1:0]   pending;
  logic [COUNT_WIDTH-1:0]   thr_q;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic [TIMEOUT_WIDTH-1:0] to_q;

  logic                     ev;
  logic [COUNT_WIDTH-1:0]   thr_eff;
  logic [COUNT_WIDTH-1:0]   acc_n;
  logic [TIMEOUT_WIDTH-1:0] timer_n;
  logic                     timeout_hit;
  logic                     pend_sat;
  logic                     drop;
  logic [COUNT_WIDTH-1:0]   pend_n;

  always_comb begin
    ev          = pulse_in & enable;
    thr_eff     = (threshold == '0) ? CNT_ONE : threshold;
    acc_n       = acc + COUNT_WIDTH'(ev);
    timer_n     = (timer == TMR_MAX) ? timer : timer + TIMEOUT_WIDTH'(enable);
    timeout_hit = (to_q != '0) && (timer_n == to_q);
    pend_sat    = (pending == CNT_MAX);
    // Buffered pulses only accrue while a report is outstanding or about to be.
    drop        = ev & pend_sat & ((state == REPORT) || (state == RELOAD));
    pend_n      = pending + COUNT_WIDTH'(ev & ~pend_sat);
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      pending   <= '0;
      thr_q     <= '0;
      timer     <= '0;
      to_q      <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= drop | (overflow & ~clear_overflow);
      case (state)
        IDLE: begin
          if (ev) begin
            acc   <= CNT_ONE;
            timer <= '0;
            thr_q <= thr_eff;
            to_q  <= timeout;
            if (thr_eff == CNT_ONE) begin
              out_count <= CNT_ONE;
              out_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          acc   <= acc_n;
          timer <= timer_n;
          if ((acc_n >= thr_q) || timeout_hit) begin
            out_count <= acc_n;
            out_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        RELOAD: begin
          pending   <= pend_n;
          out_valid <= 1'b1;
          state     <= REPORT;
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pending   <= '0;
            if (pend_n == '0) begin
              state <= IDLE;
            end else begin
              // Buffered pulses seed the next batch with freshly latched settings.
              acc   <= pend_n;
              timer <= '0;
              thr_q <= thr_eff;
              to_q  <= timeout;
              if (pend_n >= thr_eff) begin
                out_count <= pend_n;
                state     <= RELOAD;
              end else begin
                state <= ACCUM;
              end
            end
          end else begin
            pending <= pend_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
